// File: rtl/goodie_scheduler.sv
// goodie_scheduler
//
// Frame-driven controller for a pool of collectible goodie sprites. On each
// accepted frame tick it walks the slots one per cycle, scrolling active
// goodies left and retiring those that would leave the screen. It then runs
// one spawn step that places a new goodie at the right edge with a
// pseudo-random height every SPAWN_PERIOD frames. Collision hits are accepted
// in every state and retire the hit goodie immediately.
//
// Optional feature: define GOODIE_SPEEDUP_EN to make the scroll step grow by
// one pixel per frame for every eight collections, capped at 2*STEP_X.
//
// Ports:
//   clk             system clock
//   initialize_n    asynchronous active-low reset
//   enable          game running; frame ticks are ignored while low
//   frame_tick      one-cycle pulse per video frame
//   hit_valid       collision detector reports a hit this cycle
//   hit_slot        slot index of the hit
//   goodie_x_bus    slot i X position at bits [11i+10:11i]
//   goodie_y_bus    slot i Y position at bits [10i+9:10i]
//   active          per-slot occupied/drawable flag
//   collect_pulse   one-cycle pulse per accepted hit
//   collected_count saturating count of accepted hits
//   busy            frame update sequence in progress

module goodie_scheduler #(
    parameter int          NUM_SLOTS    = 4,
    parameter logic [10:0] X_START      = 11'd640,
    parameter logic [9:0]  Y_MIN        = 10'd40,
    parameter logic [5:0]  STEP_X       = 6'd5,
    parameter logic [7:0]  SPAWN_PERIOD = 8'd90,
    parameter logic [9:0]  LFSR_SEED    = 10'h2A5
) (
    input  logic                    clk,
    input  logic                    initialize_n,
    input  logic                    enable,
    input  logic                    frame_tick,
    input  logic                    hit_valid,
    input  logic [2:0]              hit_slot,
    output logic [NUM_SLOTS*11-1:0] goodie_x_bus,
    output logic [NUM_SLOTS*10-1:0] goodie_y_bus,
    output logic [NUM_SLOTS-1:0]    active,
    output logic                    collect_pulse,
    output logic [7:0]              collected_count,
    output logic                    busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MOVE  = 2'd1;
    localparam logic [1:0] ST_SPAWN = 2'd2;

    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);
    localparam logic [3:0] SLOT_LIMIT = 4'(NUM_SLOTS);

    logic [1:0]           state;
    logic [2:0]           idx;
    logic                 pending;
    logic [5:0]           step_q;
    logic [7:0]           spawn_cnt;
    logic [9:0]           lfsr;
    logic [10:0]          x_q [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] active_q;

    logic                 start;
    logic                 hit_ok;
    logic [7:0]           active_pad;
    logic [9:0]           lfsr_next;
    logic                 free_found;
    logic [2:0]           free_idx;
    logic                 spawn_due;
    logic                 spawn_go;
    logic [5:0]           step_next;

    // Sequence start: a fresh tick or a remembered one, only while enabled
    // and only from IDLE.
    assign start = (state == ST_IDLE) && enable && (frame_tick || pending);

    // Pad the active vector to the full 3-bit index range so that an
    // out-of-range hit_slot never indexes past the real slots.
    assign active_pad = 8'(active_q);
    assign hit_ok     = hit_valid && ({1'b0, hit_slot} < SLOT_LIMIT)
                        && active_pad[hit_slot];

    // Fibonacci LFSR x^10 + x^7 + 1, shifting left with feedback into bit 0.
    assign lfsr_next = {lfsr[8:0], lfsr[9] ^ lfsr[6]};

    assign spawn_due = (spawn_cnt == SPAWN_PERIOD - 8'd1);
    assign spawn_go  = (state == ST_SPAWN) && spawn_due && free_found;

    // Lowest-index free slot. A slot being hit this cycle is still active
    // here, so a spawn can never land on it.
    always_comb begin
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

`ifdef GOODIE_SPEEDUP_EN
    // Step grows with every eight collections, capped at twice the base.
    logic [5:0] step_sum;
    logic [5:0] step_cap;

    always_comb begin
        step_sum  = STEP_X + {1'b0, collected_count[7:3]};
        step_cap  = {STEP_X[4:0], 1'b0};
        step_next = (step_sum > step_cap) ? step_cap : step_sum;
    end
`else
    // Constant scroll speed.
    always_comb begin
        step_next = STEP_X;
    end
`endif

    // Frame sequencer: IDLE -> MOVE (one slot per cycle) -> SPAWN -> IDLE.
    // busy covers the whole sequence plus the cycle after SPAWN, so it is
    // derived from the state being left rather than the state being entered.
    always_ff @(posedge clk or negedge initialize_n) begin
        if (!initialize_n) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            pending   <= 1'b0;
            step_q    <= STEP_X;
            spawn_cnt <= 8'd0;
            lfsr      <= LFSR_SEED;
            busy      <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) || start;

            if (start) begin
                pending <= 1'b0;
            end else if ((state != ST_IDLE) && enable && frame_tick) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_MOVE;
                        idx    <= 3'd0;
                        step_q <= step_next;
                    end
                end
                ST_MOVE: begin
                    if (idx == LAST_SLOT) begin
                        state <= ST_SPAWN;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_SPAWN: begin
                    lfsr <= lfsr_next;
                    if (spawn_due) begin
                        if (free_found) begin
                            spawn_cnt <= 8'd0;
                        end
                    end else begin
                        spawn_cnt <= spawn_cnt + 8'd1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot storage. Priority per slot: a hit retires it, otherwise MOVE
    // scrolls or retires it, otherwise SPAWN may fill it. The retire test
    // compares before subtracting so X never wraps.
    always_ff @(posedge clk or negedge initialize_n) begin
        if (!initialize_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= X_START;
                y_q[i] <= Y_MIN;
            end
            active_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (hit_ok && (hit_slot == 3'(i))) begin
                    active_q[i] <= 1'b0;
                end else if ((state == ST_MOVE) && (idx == 3'(i)) && active_q[i]) begin
                    if (x_q[i] < {5'b0, step_q}) begin
                        active_q[i] <= 1'b0;
                    end else begin
                        x_q[i] <= x_q[i] - {5'b0, step_q};
                    end
                end else if (spawn_go && (free_idx == 3'(i))) begin
                    x_q[i]      <= X_START;
                    y_q[i]      <= Y_MIN + {1'b0, lfsr_next[8:0]};
                    active_q[i] <= 1'b1;
                end
            end
        end
    end

    // Collection bookkeeping: registered pulse and saturating counter.
    always_ff @(posedge clk or negedge initialize_n) begin
        if (!initialize_n) begin
            collect_pulse   <= 1'b0;
            collected_count <= 8'd0;
        end else begin
            collect_pulse <= hit_ok;
            if (hit_ok && (collected_count != 8'd255)) begin
                collected_count <= collected_count + 8'd1;
            end
        end
    end

    // Flatten slot registers onto the output buses.
    always_comb begin
        goodie_x_bus = '0;
        goodie_y_bus = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            goodie_x_bus[11*i +: 11] = x_q[i];
            goodie_y_bus[10*i +: 10] = y_q[i];
        end
    end

    assign active = active_q;

endmodule
